mem_bus_arbiter: RTL and testbench

//   Shares the single-port unified instruction/data memory between the multicycle core (CPU port) and the debug/program loader (DBG port).
//   Non-preemptive round-robin; one transaction in flight. Requesters see a req/ack handshake and tolerate any fixed memory read latency.

---
 rtl/mem_bus_arbiter.sv | 109 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and debug loader.
// One transaction in flight; req/ack handshake; tolerates a fixed read latency of 1..15.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t     state;
  logic       last_grant;
  logic       we_q;
  logic       pick;
  logic       sel_we;
  logic [3:0] cnt;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    pick = dbg_req;
    if (cpu_req && dbg_req) pick = ~last_grant;
    sel_we = pick ? dbg_we : cpu_we;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      grant_owner <= 1'b0;
      we_q        <= 1'b0;
      cnt         <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
      cpu_rdata   <= '0;
      dbg_rdata   <= '0;
    end else begin
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_req || dbg_req) begin
            grant_owner <= pick;
            last_grant  <= pick;
            we_q        <= sel_we;
            mem_addr    <= pick ? dbg_addr  : cpu_addr;
            mem_wdata   <= pick ? dbg_wdata : cpu_wdata;
            mem_rd      <= ~sel_we;
            mem_wr      <= sel_we;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (we_q) begin
            cpu_ack <= ~grant_owner;
            dbg_ack <= grant_owner;
            state   <= S_RESP;
          end else begin
            cnt   <= 4'(MEM_LATENCY - 1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            if (grant_owner) dbg_rdata <= mem_rdata;
            else             cpu_rdata <= mem_rdata;
            cpu_ack <= ~grant_owner;
            dbg_ack <= grant_owner;
            state   <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: latency-2 instance for the main scenarios, latency-1 instance
// for back-to-back reads; acks are scored against a queue of expected completions.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_ack, dbg_ack, mem_rd, mem_wr, busy, grant_owner;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_dbg_addr, b_dbg_wdata;
  logic        b_cpu_ack, b_dbg_ack, b_mem_rd, b_mem_wr, b_busy, b_grant_owner;
  logic [31:0] b_cpu_rdata, b_dbg_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_owner(grant_owner));

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
    .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .grant_owner(b_grant_owner));

  // Memory model: data appears exactly MEM_LATENCY cycles after the read strobe, garbage otherwise.
  typedef struct packed { logic v; logic [31:0] d; } rd_t;
  logic [31:0] m [0:15] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0,
                            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  rd_t p1 = '0, p2 = '0, q1 = '0;
  int  cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1  <= {mem_rd, m[mem_addr[5:2]]};
    p2  <= p1;
    q1  <= {b_mem_rd, m[b_mem_addr[5:2]]};
    if (mem_wr) m[mem_addr[5:2]] <= mem_wdata;
  end
  assign mem_rdata   = p2.v ? p2.d : 32'hBAD0BAD0;
  assign b_mem_rdata = q1.v ? q1.d : 32'hBAD0BAD0;

  typedef struct { logic port; int cyc; logic rd; logic [31:0] data; } exp_t;
  exp_t sb[$];
  exp_t sb_b[$];
  int   nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("ack_both", cpu_ack & dbg_ack, 0);
      if (cpu_ack || dbg_ack) begin
        if (sb.size() == 0) chk("unexp_ack", {cpu_ack, dbg_ack}, 0);
        else begin
          e = sb.pop_front();
          chk("ack_port", dbg_ack, e.port);
          chk("ack_cyc", cyc, e.cyc);
          chk("ack_owner", grant_owner, e.port);
          if (e.rd) chk("ack_rdata", e.port ? dbg_rdata : cpu_rdata, e.data);
        end
      end
      if (b_cpu_ack || b_dbg_ack) begin
        if (sb_b.size() == 0) chk("b_unexp_ack", {b_cpu_ack, b_dbg_ack}, 0);
        else begin
          e = sb_b.pop_front();
          chk("b_ack_port", b_dbg_ack, e.port);
          chk("b_ack_cyc", cyc, e.cyc);
          chk("b_ack_owner", b_grant_owner, e.port);
          chk("b_ack_rdata", b_cpu_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    {cpu_req, cpu_we, dbg_req, dbg_we} = '0;
    {cpu_addr, cpu_wdata, dbg_addr, dbg_wdata} = '0;
    {b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we} = '0;
    {b_cpu_addr, b_cpu_wdata, b_dbg_addr, b_dbg_wdata} = '0;
    tick; tick;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {mem_rd, mem_wr, cpu_ack, dbg_ack}, 0);
    chk("rst_owner", grant_owner, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
    tick;
    rst = 1'b0;

    // CPU read, latency 2
    t = cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    sb.push_back('{1'b0, t + 4, 1'b1, 32'hDEADBEEF});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t1_mem_rd", mem_rd, cyc == t + 1);
      chk("t1_mem_wr", mem_wr, 0);
      if (cyc == t + 1) chk("t1_addr", mem_addr, 32'h10);
      tick;
    end
    cpu_req = 0;
    chk("t1_dbg_rdata", dbg_rdata, 0);

    // DBG write
    t = cyc;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678;
    sb.push_back('{1'b1, t + 2, 1'b0, 32'h0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_mem_wr", mem_wr, cyc == t + 1);
      chk("t2_mem_rd", mem_rd, 0);
      if (cyc == t + 1) chk("t2_addr_data", {mem_addr, mem_wdata}, {32'h20, 32'h12345678});
      tick;
    end
    dbg_req = 0;
    chk("t2_dbg_rdata", dbg_rdata, 0);
    chk("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // Reset, then both ports hammer with writes: strict alternation starting at CPU
    rst = 1; tick; rst = 0;
    t = cyc;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h34; dbg_wdata = 32'h2;
    sb.push_back('{1'b0, t + 2,  1'b0, 32'h0});
    sb.push_back('{1'b1, t + 5,  1'b0, 32'h0});
    sb.push_back('{1'b0, t + 8,  1'b0, 32'h0});
    sb.push_back('{1'b1, t + 11, 1'b0, 32'h0});
    repeat (12) tick;
    cpu_req = 0; dbg_req = 0;

    // DBG arrives during CPU read WAIT; CPU address changes mid-flight
    t = cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    sb.push_back('{1'b0, t + 4, 1'b1, 32'hDEADBEEF});
    sb.push_back('{1'b1, t + 9, 1'b1, 32'hA5A5A5A5});
    tick;
    cpu_addr = 32'h3C;
    tick;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h0;
    @(negedge clk);
    chk("t4_busy", busy, 1);
    tick;
    @(negedge clk);
    chk("t4_addr_hold", mem_addr, 32'h10);
    tick; tick;
    cpu_req = 0;
    tick;
    @(negedge clk);
    chk("t4_dbg_issue", {mem_rd, grant_owner, mem_addr}, {1'b1, 1'b1, 32'h0});
    repeat (4) tick;
    dbg_req = 0;
    chk("t4_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // Reset during WAIT aborts the read; CPU wins the first tie afterwards
    t = cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
    tick; tick;
    rst = 1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h38; dbg_wdata = 32'hCAFE;
    tick;
    rst = 0;
    sb.push_back('{1'b0, t + 7,  1'b1, 32'h5A5A5A5A});
    sb.push_back('{1'b1, t + 10, 1'b0, 32'h0});
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_strobes", {mem_rd, mem_wr, cpu_ack, dbg_ack}, 0);
    chk("t5_rdata", {cpu_rdata, dbg_rdata}, 0);
    repeat (5) tick;
    cpu_req = 0;
    repeat (3) tick;
    dbg_req = 0;

    // Latency-1 instance: back-to-back CPU reads, req held across the ack
    t = cyc;
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 32'h0;
    sb_b.push_back('{1'b0, t + 3, 1'b1, 32'hA5A5A5A5});
    sb_b.push_back('{1'b0, t + 7, 1'b1, 32'h5A5A5A5A});
    tick;
    @(negedge clk);
    chk("t6_busy", b_busy, 1);
    repeat (3) tick;
    b_cpu_addr = 32'h4;
    repeat (4) tick;
    b_cpu_req = 0;
    chk("t6_quiet", {b_mem_wr, b_mem_wdata, b_dbg_rdata}, 0);

    repeat (3) tick;
    chk("sb_empty", sb.size(), 0);
    chk("sb_b_empty", sb_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
